// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline.
//   - ALU operation codes driven on alu_ctl
//   - forwarding source selection encoding
//   - packed ID/EX register layout
//   - fwd_select(): priority decision for one source operand
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SRLV = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1111;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // Everything the ID/EX register holds; all-zero is a bubble.
  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm;
    logic              alusrc;
    logic [3:0]        aluctl;
    logic              shiftc;
    logic [REG_W-1:0]  shamt;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
  } id_ex_t;

  // EX/MEM is the younger producer, so it wins over MEM/WB. Register 0 is
  // hard-wired to zero and is never a forwarding target.
  function automatic fwd_sel_e fwd_select(
    input logic             exmem_regwrite,
    input logic [REG_W-1:0] exmem_rd,
    input logic             memwb_regwrite,
    input logic [REG_W-1:0] memwb_rd,
    input logic [REG_W-1:0] src
  );
    if (exmem_regwrite && exmem_rd != '0 && exmem_rd == src) return FWD_EXMEM;
    if (memwb_regwrite && memwb_rd != '0 && memwb_rd == src) return FWD_MEMWB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Forwarding multiplexer for one EX-stage source operand.
//   src            : register number of the operand
//   read_val       : value read from the register file in ID
//   exmem_*        : EX/MEM write-back candidate
//   memwb_*        : MEM/WB write-back candidate
//   value          : operand value after forwarding
module fwd_mux
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0]  src,
  input  logic [DATA_W-1:0] read_val,
  input  logic              exmem_regwrite,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] value
);

  fwd_sel_e sel;

  always_comb begin
    sel = fwd_select(exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd, src);
    // NOTE: a default on every path keeps this block free of inferred latches.
    case (sel)
      FWD_EXMEM: value = exmem_result;
      FWD_MEMWB: value = memwb_result;
      default:   value = read_val;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus EX-stage operand selection.
//   clk, reset         : clock, synchronous active-high reset (loads a bubble)
//   id_*               : decoded instruction from ID
//   flush              : redirect, kill the instruction entering EX
//   hold               : downstream stall, freeze this stage
//   exmem_*, memwb_*   : forwarding sources
//   lu_stall           : load-use hazard, freeze PC and IF/ID this cycle
//   alu_a/alu_b/alu_*  : ALU operands and control
//   ex_*               : registered control/destination for EX/MEM
//   ex_store_data      : forwarded rt value for stores
module id_ex_stage
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rs_val,
  input  logic [DATA_W-1:0] id_rt_val,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alusrc,
  input  logic [3:0]        id_aluctl,
  input  logic              id_shiftc,
  input  logic [REG_W-1:0]  id_shamt,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              flush,
  input  logic              hold,
  input  logic              exmem_regwrite,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              lu_stall,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctl,
  output logic              alu_shiftc,
  output logic [REG_W-1:0]  alu_shiftv,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_store_data
);

  id_ex_t q;
  id_ex_t d;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;

  // A load in EX whose destination is read by the instruction in ID cannot
  // forward in time. rt counts as a use when it feeds the ALU or is store data.
  always_comb begin
    lu_stall = q.valid && q.memread && (q.rd != '0) && id_valid &&
               ((q.rd == id_rs) ||
                ((q.rd == id_rt) && (!id_alusrc || id_memwrite)));
  end

  // Next contents on a normal load; control bits only count for real
  // instructions so a not-valid slot never writes anything downstream.
  always_comb begin
    d          = '0;
    d.valid    = id_valid;
    d.rs       = id_rs;
    d.rt       = id_rt;
    d.rd       = id_rd;
    d.rs_val   = id_rs_val;
    d.rt_val   = id_rt_val;
    d.imm      = id_imm;
    d.alusrc   = id_alusrc;
    d.aluctl   = id_aluctl;
    d.shiftc   = id_shiftc;
    d.shamt    = id_shamt;
    d.regwrite = id_regwrite & id_valid;
    d.memread  = id_memread  & id_valid;
    d.memwrite = id_memwrite & id_valid;
    d.memtoreg = id_memtoreg & id_valid;
  end

  // Priority: reset > flush > hold > load-use bubble > load.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      q <= '0;
    end else if (!hold) begin
      if (lu_stall) q <= '0;
      else          q <= d;
    end
  end

  fwd_mux u_fwd_rs (
    .src            (q.rs),
    .read_val       (q.rs_val),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .value          (rs_fwd)
  );

  fwd_mux u_fwd_rt (
    .src            (q.rt),
    .read_val       (q.rt_val),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .value          (rt_fwd)
  );

  always_comb begin
    alu_a         = rs_fwd;
    alu_b         = q.alusrc ? q.imm : rt_fwd;
    ex_store_data = rt_fwd;
    alu_ctl       = q.aluctl;
    alu_shiftc    = q.shiftc;
    alu_shiftv    = q.shamt;
    ex_valid      = q.valid;
    ex_regwrite   = q.regwrite;
    ex_memread    = q.memread;
    ex_memwrite   = q.memwrite;
    ex_memtoreg   = q.memtoreg;
    ex_rd         = q.rd;
  end

endmodule
